// File: rtl/mod12_counter.sv
// Free-running modulo-MODULUS up-counter with decoded terminal count,
// registered wrap strobe and one-hot state outputs.
module mod12_counter #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [WIDTH-1:0]   q,
    output logic               tc,
    output logic               wrap,
    output logic [MODULUS-1:0] q_onehot
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] qNext;
    logic             wrapNext;
    logic             illegal;

    // One extra bit so the compare still works when MODULUS == 2**WIDTH.
    assign illegal = ({1'b0, q} >= (WIDTH+1)'(MODULUS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= qNext;
            wrap <= wrapNext;
        end
    end

    always_comb begin
        qNext    = q + WIDTH'(1);
        wrapNext = 1'b0;
        if (q == LAST) begin
            qNext    = '0;
            wrapNext = 1'b1;
        end else if (illegal) begin
            qNext    = '0;
        end
    end

    // Illegal codes match no index, so q_onehot falls to all zeros.
    always_comb begin
        tc = (q == LAST);
        for (int i = 0; i < MODULUS; i++) begin
            q_onehot[i] = (q == WIDTH'(i));
        end
    end

endmodule

// File: tb/tb_mod12_counter.sv
// Directed self-checking bench for mod12_counter: power-up, full count
// sequence, mid-count reset, held reset and illegal-state recovery.
module tb_mod12_counter;

    typedef struct {
        logic       rst;
        logic [3:0] q;
        logic       tc;
        logic       wrap;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [3:0]  q;
    logic        tc;
    logic        wrap;
    logic [11:0] q_onehot;

    logic clkRun;
    int   checks;
    int   errors;
    int   wrapCount;
    int   tcCount;
    vec_t vectors[24];

    mod12_counter #(.MODULUS(12), .WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .q(q),
        .tc(tc),
        .wrap(wrap),
        .q_onehot(q_onehot)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clkRun) clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset = v.rst;
        tick();
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expQ,
                            input logic expTc, input logic expWrap);
        checkOutput({tag, " q"}, 32'(q), 32'(expQ));
        checkOutput({tag, " tc"}, 32'(tc), 32'(expTc));
        checkOutput({tag, " wrap"}, 32'(wrap), 32'(expWrap));
        checkOutput({tag, " onehot"}, 32'(q_onehot), 32'(12'h001) << expQ);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        wrapCount = 0;
        tcCount   = 0;
        clkRun    = 1'b0;

        // After release, edge i leaves q = (i+1) mod 12; wrap marks the 11->0 step.
        for (int i = 0; i < 24; i++) begin
            vectors[i].rst  = 1'b1;
            vectors[i].q    = 4'((i + 1) % 12);
            vectors[i].tc   = (((i + 1) % 12) == 11);
            vectors[i].wrap = (((i + 1) % 12) == 0);
        end

        reset = 1'b0;
        #13;
        checkAll("powerup", 4'd0, 1'b0, 1'b0);

        clkRun = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("held reset q", 32'(q), 32'd0);
            checkOutput("held reset wrap", 32'(wrap), 32'd0);
        end

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vectors[i]);
            checkAll($sformatf("edge%0d", i + 1), vectors[i].q, vectors[i].tc, vectors[i].wrap);
            if (wrap) wrapCount++;
            if (tc) tcCount++;
        end
        checkOutput("wrap pulse count", 32'(wrapCount), 32'd2);
        checkOutput("tc pulse count", 32'(tcCount), 32'd2);

        for (int i = 0; i < 7; i++) tick();
        checkAll("before midreset", 4'd7, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkAll("async clear", 4'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        tick();
        checkAll("after release", 4'd1, 1'b0, 1'b0);

        tick();
        force dut.q = 4'he;
        #1;
        checkOutput("illegal onehot", 32'(q_onehot), 32'd0);
        checkOutput("illegal tc", 32'(tc), 32'd0);
        #1;
        release dut.q;
        #1;
        checkOutput("illegal held q", 32'(q), 32'he);
        tick();
        checkAll("recovered", 4'd0, 1'b0, 1'b0);
        tick();
        checkAll("post recovery", 4'd1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
